seq_mul8_1122: RTL and testbench
================================

Name: seq_mul8_1122

Overview:
- Handshaked, multi-cycle sequencer for an 8x8 approximate multiplier.
- Time-shares one ap1 and one ap2 4x4 instance across two phases instead of the four parallel quadrant multipliers.
- Accumulates the partial products exactly and holds the 16-bit product until the consumer accepts it.
- Sits between an operand source and a result sink in the multiplier test and characterisation datapaths, where area matters more than throughput.

Parameters:
- CNT_W, 16, width of the completed-operation counter (saturating).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  8  multiplicand.
- b  input  8  multiplier.
- out_valid  output  1  prod is valid.
- out_ready  input  1  sink accepts prod this cycle.
- prod  output  16  approximate product.
- busy  output  1  high in any state other than IDLE.
- op_cnt  output  CNT_W  number of results accepted by the sink.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, prod=0, busy=0, op_cnt=0. All internal operand and accumulator registers are also cleared.
- Nibble split: ah=a[7:4], al=a[3:0], bh=b[7:4], bl=b[3:0].
- ap1 always receives ah; ap2 always receives al.
- Shared b-nibble mux: bh in PH0, bl in PH1.
- FSM states: IDLE, PH0, PH1, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid, latch a/b, clear acc, go to PH0.
- PH0:
  - hh = ap1(ah,bh); lh = ap2(al,bh).
  - acc <= (hh<<8) + (lh<<4).
  - Go to PH1.
- PH1:
  - hl = ap1(ah,bl); ll = ap2(al,bl).
  - acc <= acc + (hl<<4) + ll.
  - Go to DONE.
- DONE:
  - out_valid=1, prod=acc.
  - If out_ready, out_valid drops next cycle, op_cnt increments, go to IDLE.
- Arithmetic:
  - Exact 17-bit internal sum, truncated to 16 bits for prod. Overflow is impossible for 8-bit partials but truncation is still specified.
  - prod = (hh<<8) + ((hl+lh)<<4) + ll, truncated to [15:0].
- Latency: operands accepted at edge N; out_valid high from edge N+3.
- Throughput: one result per 4 cycles minimum, including the IDLE accept cycle.
- in_ready is high only in IDLE. in_valid in any other state is ignored and not queued.
- a/b may change freely after acceptance; only the latched copies are used.
- prod and out_valid stay stable while out_valid=1 and out_ready=0 (back-pressure hold, any duration).
- out_ready while out_valid=0 has no effect.
- op_cnt saturates at all-ones and never wraps.
- busy = (state != IDLE).
- Reset mid-operation (any state): immediately returns to reset values. The in-flight result is discarded and not counted.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Golden model: ap1/ap2 behavioural 4x4 models plus the exact sum formula above; every prod is checked against it.
- Basic op: a=0xB7, b=0x5C, in_valid pulsed at cycle 0, out_ready=1 -> out_valid high at cycle 3 only, prod=golden(0xB7,0x5C), op_cnt=1, in_ready high again at cycle 4.
- Back-pressure: a=0xFF, b=0xFF, out_ready=0 for 10 cycles, then 1 -> prod/out_valid stable for all 10 cycles, single op_cnt increment, in_ready=0 throughout the hold.
- Ignored input: new a=0x12, b=0x34 asserted with in_valid during PH0/PH1/DONE -> not accepted; the result still matches the first pair (0x0F, 0xF0).
- Back-to-back: in_valid held high with 16 random pairs, out_ready=1 -> 16 results in order, spaced 4 cycles apart, all matching golden, op_cnt=16.
- Reset mid-op: rst_n asserted asynchronously between clock edges during PH1 of a=0x80, b=0x80 -> outputs at reset values immediately, op_cnt=0; a following a=0x01, b=0x01 completes normally.
- Saturation: CNT_W=2, run 5 operations -> op_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/seq_mul8_1122.sv
// Handshaked 8x8 approximate multiplier that time-shares one ap1 and one ap2 4x4 unit
// over two phases. ap1 drops the two LSB result columns; ap2 replaces bit 0 with x[0]|y[0].
module seq_mul8_1122 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      prod,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {StIdle, StPh0, StPh1, StDone} state_t;

    state_t           state_q, state_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [16:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       b_nib;
    logic [7:0]       p1, p2;

    function automatic logic [7:0] ap1(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = {4'b0000, x} * {4'b0000, y};
        return {p[7:2], 2'b00};
    endfunction

    function automatic logic [7:0] ap2(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = {4'b0000, x} * {4'b0000, y};
        return {p[7:1], x[0] | y[0]};
    endfunction

    // Shared b nibble: high half in PH0, low half otherwise (only PH1 uses it).
    always_comb begin
        b_nib = (state_q == StPh0) ? b_q[7:4] : b_q[3:0];
        p1    = ap1(a_q[7:4], b_nib);
        p2    = ap2(a_q[3:0], b_nib);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    state_d = StPh0;
                end
            end
            StPh0: begin
                acc_d   = {1'b0, p1, 8'h00} + {5'b00000, p2, 4'h0};
                state_d = StPh1;
            end
            StPh1: begin
                acc_d   = acc_q + {5'b00000, p1, 4'h0} + {9'h000, p2};
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only, so no input-to-output combinational path.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign prod      = acc_q[15:0];
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_seq_mul8_1122.sv
// Directed bench for seq_mul8_1122: one default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_seq_mul8_1122;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  a = '0, b = '0;
    logic        in_ready, out_valid, busy;
    logic [15:0] prod;
    logic [15:0] op_cnt;

    logic        in_valid2 = 1'b0;
    logic        in_ready2, out_valid2, busy2;
    logic [15:0] prod2;
    logic [1:0]  op_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    seq_mul8_1122 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .busy(busy), .op_cnt(op_cnt)
    );

    seq_mul8_1122 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
        .prod(prod2), .busy(busy2), .op_cnt(op_cnt2)
    );

    // Reference models: ap1 truncates result bits [1:0]; ap2 computes bit 0 as x0|y0.
    function automatic int m_ap1(input int x, input int y);
        return ((x * y) / 4) * 4;
    endfunction

    function automatic int m_ap2(input int x, input int y);
        int p;
        p = x * y;
        return (p - (p % 2)) + (((x % 2) == 1 || (y % 2) == 1) ? 1 : 0);
    endfunction

    function automatic int golden(input int av, input int bv);
        int ah, al, bh, bl, s;
        ah = av / 16; al = av % 16; bh = bv / 16; bl = bv % 16;
        s = m_ap1(ah, bh) * 256 + (m_ap1(ah, bl) + m_ap2(al, bh)) * 16 + m_ap2(al, bl);
        return s % 65536;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks then happen mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] va [16] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h7E, 8'h81, 8'h3C, 8'hC3,
                             8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h2D, 8'hD2};
    logic [7:0] vb [16] = '{8'hFF, 8'h00, 8'h37, 8'h5A, 8'hE7, 8'h18, 8'hC3, 8'h3C,
                             8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h69, 8'h96, 8'hD2, 8'h2D};

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod", prod, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_cnt", op_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic op: 0xB7 * 0x5C, hand-computed approx product 0x3EC5
        cyc();
        a = 8'hB7; b = 8'h5C; in_valid = 1'b1; out_ready = 1'b1;
        chk("basic_c0_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        chk("basic_c1_out_valid", out_valid, 0);
        chk("basic_c1_in_ready", in_ready, 0);
        chk("basic_c1_busy", busy, 1);
        cyc();
        chk("basic_c2_out_valid", out_valid, 0);
        cyc();
        chk("basic_c3_out_valid", out_valid, 1);
        chk("basic_c3_prod", prod, 16'h3EC5);
        chk("basic_c3_model", prod, golden(8'hB7, 8'h5C));
        cyc();
        exp_cnt++;
        chk("basic_c4_out_valid", out_valid, 0);
        chk("basic_c4_in_ready", in_ready, 1);
        chk("basic_c4_op_cnt", op_cnt, exp_cnt);

        // Back-pressure: 0xFF * 0xFF held for 10 cycles, expected 0xFCF1
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_prod", prod, 16'hFCF1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_op_cnt", op_cnt, exp_cnt);
            cyc();
        end
        chk("bp_hold_end_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        exp_cnt++;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_cnt", op_cnt, exp_cnt);

        // Ignored input: 0x0F * 0xF0 (expected 0x0E11) while 0x12/0x34 is offered
        a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
        cyc();
        a = 8'h12; b = 8'h34;
        cyc();
        chk("ign_ph1_in_ready", in_ready, 0);
        cyc();
        chk("ign_done_valid", out_valid, 1);
        chk("ign_done_prod", prod, 16'h0E11);
        cyc();
        in_valid = 1'b0;
        exp_cnt++;
        chk("ign_idle_in_ready", in_ready, 1);
        cyc();
        chk("ign_not_queued_busy", busy, 0);

        // Back-to-back: in_valid held, results every 4 cycles
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a = va[k]; b = vb[k];
            chk("b2b_idle_ready", in_ready, 1);
            cyc();
            a = ~va[k]; b = ~vb[k];
            chk("b2b_ph0_valid", out_valid, 0);
            cyc();
            chk("b2b_ph1_valid", out_valid, 0);
            cyc();
            chk("b2b_done_valid", out_valid, 1);
            chk("b2b_prod", prod, golden(va[k], vb[k]));
            cyc();
            exp_cnt++;
        end
        in_valid = 1'b0;
        chk("b2b_op_cnt", op_cnt, exp_cnt);
        chk("b2b_op_cnt_abs", op_cnt, 19);

        // Reset between edges during PH1 of 0x80 * 0x80
        cyc();
        a = 8'h80; b = 8'h80; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("rmid_ph1_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_in_ready", in_ready, 1);
        chk("rmid_out_valid", out_valid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_prod", prod, 0);
        chk("rmid_op_cnt", op_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        cyc();
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("rpost_valid", out_valid, 1);
        chk("rpost_prod", prod, 16'h0011);
        cyc();
        exp_cnt++;
        chk("rpost_op_cnt", op_cnt, exp_cnt);

        // Saturation on the CNT_W=2 instance: 1,2,3,3,3
        for (int k = 0; k < 5; k++) begin
            a = va[k + 2]; b = vb[k + 2]; in_valid2 = 1'b1;
            cyc();
            in_valid2 = 1'b0;
            cyc();
            cyc();
            chk("sat_prod", prod2, golden(va[k + 2], vb[k + 2]));
            cyc();
            chk("sat_op_cnt", op_cnt2, (k < 3) ? k + 1 : 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
